irq_dispatch_sequencer: RTL and testbench
=========================================

# irq_dispatch_sequencer

- Sits between the interrupt controller's priority-queue output and the CPU.
- Takes the head pending request (device address byte plus 3-bit priority) and admits it only when it strictly out-ranks the CPU's current priority.
- Raises `irq` with a 16-bit vector and completes a handshake with the CPU.
- Keeps a nesting stack of preempted CPU priorities, which is popped on return-from-interrupt.

## Interface
Parameters:
- `NEST_DEPTH`, 8: nesting stack entries (2..15).
- `VEC_HI`, 8'hFF: high byte of the vector; vector = {VEC_HI, device byte}.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  interrupt controller head entry present.
- `req_dev`  in  8  head entry device address low byte.
- `req_pri`  in  3  head entry priority (PSW[7:5] of requesting device).
- `req_pop`  out  1  one-cycle pulse consuming the head entry.
- `cpu_pri`  in  3  CPU current priority (PSW[7:5]).
- `cpu_ie`  in  1  CPU global interrupt enable.
- `irq`  out  1  interrupt request to CPU.
- `vector`  out  16  vector address, valid while `irq`=1.
- `irq_ack`  in  1  CPU accepts interrupt (single-cycle pulse).
- `new_pri_valid`  out  1  one-cycle pulse: CPU loads `new_pri` into PSW[7:5].
- `new_pri`  out  3  priority of the accepted interrupt.
- `reti`  in  1  CPU executed return-from-interrupt (single-cycle pulse).
- `restore_valid`  out  1  one-cycle pulse: CPU restores `restore_pri`.
- `restore_pri`  out  3  popped preempted priority.
- `nest_level`  out  4  current stack occupancy.
- `err_underflow`  out  1  sticky; `reti` received with an empty stack.

## Operation
- FSM states IDLE, CAPTURE, PEND.
- IDLE → CAPTURE when all of the following hold at a clock edge:
  - `req_valid`=1 and `cpu_ie`=1;
  - `req_pri` > `cpu_pri` (unsigned, strict; equal priority never preempts);
  - `nest_level` < NEST_DEPTH.
- On the IDLE → CAPTURE edge, `req_dev` and `req_pri` are latched into hold registers.
- Upstream contract: the head entry does not change until it is popped.
- CAPTURE: `req_pop`=1 for exactly this cycle; unconditional next state PEND.
- PEND:
  - `irq`=1 and `vector`={VEC_HI, held dev}.
  - Stays in PEND until `irq_ack`=1 is sampled, then → IDLE.
  - `irq` is never withdrawn once raised, even if `cpu_ie` falls or a higher-priority request arrives; those wait in the queue.
- On the accepting edge:
  - `cpu_pri` is pushed onto the stack and `nest_level`+1;
  - the next cycle carries `new_pri_valid`=1 and `new_pri`=held priority.
- `irq_ack` outside PEND is ignored.
- `reti` is sampled in any state:
  - Stack non-empty: pop; the next cycle carries `restore_valid`=1 with `restore_pri`=popped value, and `nest_level`−1.
  - Stack empty: no pop, `restore_valid` stays 0, `err_underflow` is set (cleared only by `rst`).
- `reti` and accepting `irq_ack` on the same edge: the pop is performed first, then the push.
  - `restore_pri` = old top.
  - The same slot is written with `cpu_pri`.
  - `nest_level` is unchanged.
  - Both `restore_valid` and `new_pri_valid` pulse in the next cycle.
- Stack full (`nest_level`=NEST_DEPTH): IDLE qualification is blocked, so push overflow is impossible.
- `new_pri` and `restore_pri` hold their last values between pulses.

## Timing
- Reset values:
  - state IDLE, stack empty, hold registers 0;
  - `req_pop`, `irq`, `new_pri_valid`, `restore_valid`, `err_underflow` = 0;
  - `vector`, `new_pri`, `restore_pri` = 0; `nest_level` = 0.
- `rst` asserted in any state forces these values immediately (asynchronous).
- Reset while in CAPTURE or PEND loses the captured request; this is by design.
- Latency, with qualification sampled at edge N:
  - `req_pop`=1 in cycle N+1;
  - `irq`=1 from cycle N+2.
- Ack sampled at edge M: `irq`=0 and `new_pri_valid`=1 in cycle M+1; IDLE can qualify again at edge M+1.
- `reti` sampled at edge R: `restore_valid`=1 in cycle R+1.
- `nest_level` updates at the same edge that samples `irq_ack` or `reti`.
- All outputs are registered; no combinational input→output paths.

## Test plan
- `cpu_pri`=2, `cpu_ie`=1, `req_valid`=1, `req_dev`=8'hC6, `req_pri`=5 at edge 0 → `req_pop` pulse in cycle 1; `irq`=1 and `vector`=16'hFFC6 from cycle 2. `irq_ack` at edge 4 → `irq`=0 and `new_pri_valid`=1 with `new_pri`=5 in cycle 5; `nest_level`=1.
- `req_pri`=3 with `cpu_pri`=3; or `req_pri`=6 with `cpu_ie`=0 → no `req_pop` and `irq` stays 0 for 20 cycles.
- Nest three interrupts (priorities 3, 5, 7 from `cpu_pri` 0), then 3× `reti` → `restore_pri` sequence 5, 3, 0; `nest_level` goes 3→0; a fourth `reti` sets `err_underflow`=1 and produces no `restore_valid`.
- Fill the stack to NEST_DEPTH, then offer `req_pri`=7 with `cpu_pri`=6 → no capture; one `reti` → capture proceeds 1 cycle later.
- In PEND, the same-edge `reti` + `irq_ack` case (`nest_level`=2, top=4, `cpu_pri`=5) → `restore_pri`=4 and `new_pri_valid` together; `nest_level` stays 2; the next `reti` restores 5.
- Assert `rst` mid-PEND → `irq`, `vector`, `nest_level` at 0 immediately; after release, a new request is served normally.

Source files
------------

// File: rtl/irq_dispatch_sequencer.sv
// -----------------------------------------------------------------------------
// irq_dispatch_sequencer
//   Sits between the interrupt controller's priority-queue head and the CPU.
//   A head request is admitted only when it strictly out-ranks the CPU's
//   current priority. It is then popped from the queue, presented as irq plus
//   a 16-bit vector, and handed over with an ack handshake. Preempted CPU
//   priorities are kept on a nesting stack that is popped by reti.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/dev/pri        head entry of the interrupt controller queue
//   req_pop                  one-cycle pulse consuming the head entry
//   cpu_pri, cpu_ie          CPU current priority and global enable
//   irq, vector              interrupt request and vector {VEC_HI, dev}
//   irq_ack                  CPU accepts the pending interrupt
//   new_pri_valid, new_pri   pulse: CPU loads new_pri into its PSW
//   reti                     CPU returned from interrupt
//   restore_valid/pri        pulse: CPU restores the popped priority
//   nest_level               nesting stack occupancy
//   err_underflow            sticky: reti seen with an empty stack
// -----------------------------------------------------------------------------
module irq_dispatch_sequencer #(
  parameter int         NEST_DEPTH = 8,
  parameter logic [7:0] VEC_HI     = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [7:0]  req_dev,
  input  logic [2:0]  req_pri,
  output logic        req_pop,
  input  logic [2:0]  cpu_pri,
  input  logic        cpu_ie,
  output logic        irq,
  output logic [15:0] vector,
  input  logic        irq_ack,
  output logic        new_pri_valid,
  output logic [2:0]  new_pri,
  input  logic        reti,
  output logic        restore_valid,
  output logic [2:0]  restore_pri,
  output logic [3:0]  nest_level,
  output logic        err_underflow
);

  localparam int         IDX_W   = $clog2(NEST_DEPTH);
  localparam logic [3:0] DEPTH_C = 4'(NEST_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_PEND    = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [7:0]         dev_hold_r;
  logic [2:0]         pri_hold_r;
  logic [2:0]         stack_r [NEST_DEPTH];
  logic [3:0]         level_r;

  logic               qualify_s;
  logic               accept_s;
  logic               reti_pop_s;
  logic [IDX_W-1:0]   top_idx_s;
  logic [IDX_W-1:0]   push_idx_s;
  logic [2:0]         top_val_s;

  logic               req_pop_r;
  logic               irq_r;
  logic [15:0]        vector_r;
  logic               new_pri_valid_r;
  logic [2:0]         new_pri_r;
  logic               restore_valid_r;
  logic [2:0]         restore_pri_r;
  logic               err_underflow_r;

  logic               req_pop_nxt_s;
  logic               irq_nxt_s;
  logic [15:0]        vector_nxt_s;
  logic               new_pri_valid_nxt_s;
  logic [2:0]         new_pri_nxt_s;
  logic               restore_valid_nxt_s;
  logic [2:0]         restore_pri_nxt_s;
  logic               err_underflow_nxt_s;
  logic [3:0]         level_nxt_s;

  // Admission rule: strict priority win, enabled CPU, and room to push later.
  assign qualify_s  = (state_r == ST_IDLE) && req_valid && cpu_ie &&
                      (req_pri > cpu_pri) && (level_r < DEPTH_C);
  assign accept_s   = (state_r == ST_PEND) && irq_ack;
  assign reti_pop_s = reti && (level_r != 4'd0);

  // Top entry sits at level-1; a simultaneous pop+push reuses that slot.
  assign top_idx_s  = IDX_W'(level_r - 4'd1);
  assign push_idx_s = reti_pop_s ? top_idx_s : IDX_W'(level_r);
  assign top_val_s  = stack_r[top_idx_s];

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; once raised, irq is only retired by an ack.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (qualify_s) begin
          state_nxt_s = ST_CAPTURE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CAPTURE: state_nxt_s = ST_PEND;
      ST_PEND: begin
        if (irq_ack) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_PEND;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM output logic: next values of every registered output.
  always_comb begin
    req_pop_nxt_s       = (state_nxt_s == ST_CAPTURE);
    irq_nxt_s           = (state_nxt_s == ST_PEND);
    vector_nxt_s        = 16'd0;
    new_pri_valid_nxt_s = accept_s;
    new_pri_nxt_s       = new_pri_r;
    restore_valid_nxt_s = reti_pop_s;
    restore_pri_nxt_s   = restore_pri_r;
    err_underflow_nxt_s = err_underflow_r;
    level_nxt_s         = level_r;

    if (state_nxt_s == ST_PEND) begin
      vector_nxt_s = {VEC_HI, dev_hold_r};
    end else begin
      vector_nxt_s = 16'd0;
    end

    if (accept_s) begin
      new_pri_nxt_s = pri_hold_r;
    end else begin
      new_pri_nxt_s = new_pri_r;
    end

    if (reti_pop_s) begin
      restore_pri_nxt_s = top_val_s;
    end else begin
      restore_pri_nxt_s = restore_pri_r;
    end

    if (reti && (level_r == 4'd0)) begin
      err_underflow_nxt_s = 1'b1;
    end else begin
      err_underflow_nxt_s = err_underflow_r;
    end

    // Pop and push on the same edge cancel in the occupancy count.
    if (accept_s && reti_pop_s) begin
      level_nxt_s = level_r;
    end else if (accept_s) begin
      level_nxt_s = level_r + 4'd1;
    end else if (reti_pop_s) begin
      level_nxt_s = level_r - 4'd1;
    end else begin
      level_nxt_s = level_r;
    end
  end

  // Output and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_pop_r       <= 1'b0;
      irq_r           <= 1'b0;
      vector_r        <= 16'd0;
      new_pri_valid_r <= 1'b0;
      new_pri_r       <= 3'd0;
      restore_valid_r <= 1'b0;
      restore_pri_r   <= 3'd0;
      err_underflow_r <= 1'b0;
      level_r         <= 4'd0;
    end else begin
      req_pop_r       <= req_pop_nxt_s;
      irq_r           <= irq_nxt_s;
      vector_r        <= vector_nxt_s;
      new_pri_valid_r <= new_pri_valid_nxt_s;
      new_pri_r       <= new_pri_nxt_s;
      restore_valid_r <= restore_valid_nxt_s;
      restore_pri_r   <= restore_pri_nxt_s;
      err_underflow_r <= err_underflow_nxt_s;
      level_r         <= level_nxt_s;
    end
  end

  // Hold registers: the admitted head entry is latched on the qualifying edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dev_hold_r <= 8'd0;
      pri_hold_r <= 3'd0;
    end else if (qualify_s) begin
      dev_hold_r <= req_dev;
      pri_hold_r <= req_pri;
    end else begin
      dev_hold_r <= dev_hold_r;
      pri_hold_r <= pri_hold_r;
    end
  end

  // Nesting stack storage; the preempted CPU priority is pushed on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NEST_DEPTH; i++) begin
        stack_r[i] <= 3'd0;
      end
    end else if (accept_s) begin
      stack_r[push_idx_s] <= cpu_pri;
    end else begin
      stack_r[push_idx_s] <= stack_r[push_idx_s];
    end
  end

  assign req_pop       = req_pop_r;
  assign irq           = irq_r;
  assign vector        = vector_r;
  assign new_pri_valid = new_pri_valid_r;
  assign new_pri       = new_pri_r;
  assign restore_valid = restore_valid_r;
  assign restore_pri   = restore_pri_r;
  assign nest_level    = level_r;
  assign err_underflow = err_underflow_r;

endmodule

// File: tb/tb_irq_dispatch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_irq_dispatch_sequencer
//   Directed scenarios followed by a randomized run. A transaction-level model
//   (a queue as the nesting stack plus a three-phase request tracker) predicts
//   every registered output after each rising edge.
// -----------------------------------------------------------------------------
module tb_irq_dispatch_sequencer;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [7:0]  req_dev;
  logic [2:0]  req_pri;
  logic        req_pop;
  logic [2:0]  cpu_pri;
  logic        cpu_ie;
  logic        irq;
  logic [15:0] vector;
  logic        irq_ack;
  logic        new_pri_valid;
  logic [2:0]  new_pri;
  logic        reti;
  logic        restore_valid;
  logic [2:0]  restore_pri;
  logic [3:0]  nest_level;
  logic        err_underflow;

  int checks;
  int failures;

  // Reference model: phase 0 = idle, 1 = pop cycle, 2 = irq raised.
  int         m_phase;
  logic [2:0] m_stack [$];
  logic [7:0] m_dev;
  logic [2:0] m_pri;
  logic [2:0] m_new_pri;
  logic       m_new_pri_valid;
  logic [2:0] m_restore_pri;
  logic       m_restore_valid;
  logic       m_err;

  irq_dispatch_sequencer #(.NEST_DEPTH(DEPTH), .VEC_HI(8'hFF)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_dev(req_dev), .req_pri(req_pri), .req_pop(req_pop),
    .cpu_pri(cpu_pri), .cpu_ie(cpu_ie),
    .irq(irq), .vector(vector), .irq_ack(irq_ack),
    .new_pri_valid(new_pri_valid), .new_pri(new_pri),
    .reti(reti), .restore_valid(restore_valid), .restore_pri(restore_pri),
    .nest_level(nest_level), .err_underflow(err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_stack.delete();
    m_dev = 8'd0;
    m_pri = 3'd0;
    m_new_pri = 3'd0;
    m_new_pri_valid = 1'b0;
    m_restore_pri = 3'd0;
    m_restore_valid = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic check_all();
    chk("req_pop", 16'(req_pop), 16'(m_phase == 1));
    chk("irq", 16'(irq), 16'(m_phase == 2));
    if (m_phase == 2) chk("vector", vector, {8'hFF, m_dev});
    chk("new_pri_valid", 16'(new_pri_valid), 16'(m_new_pri_valid));
    chk("new_pri", 16'(new_pri), 16'(m_new_pri));
    chk("restore_valid", 16'(restore_valid), 16'(m_restore_valid));
    chk("restore_pri", 16'(restore_pri), 16'(m_restore_pri));
    chk("nest_level", 16'(nest_level), 16'(m_stack.size()));
    chk("err_underflow", 16'(err_underflow), 16'(m_err));
  endtask

  // One clock edge: apply the rules to the sampled inputs, then compare.
  task automatic tick();
    logic       i_valid, i_ie, i_ack, i_reti, was_pop;
    logic [7:0] i_dev;
    logic [2:0] i_pri, i_cpu;
    int         old_phase, old_size;
    i_valid = req_valid; i_ie = cpu_ie; i_ack = irq_ack; i_reti = reti;
    i_dev = req_dev; i_pri = req_pri; i_cpu = cpu_pri;
    old_phase = m_phase; old_size = m_stack.size();
    was_pop = (m_phase == 1);
    @(posedge clk);
    #1;
    m_restore_valid = 1'b0;
    m_new_pri_valid = 1'b0;
    if (i_reti) begin
      if (m_stack.size() > 0) begin
        m_restore_pri = m_stack.pop_back();
        m_restore_valid = 1'b1;
      end else begin
        m_err = 1'b1;
      end
    end
    if (old_phase == 2 && i_ack) begin
      m_stack.push_back(i_cpu);
      m_new_pri_valid = 1'b1;
      m_new_pri = m_pri;
      m_phase = 0;
    end else if (old_phase == 1) begin
      m_phase = 2;
    end else if (old_phase == 0 && i_valid && i_ie && (i_pri > i_cpu) && old_size < DEPTH) begin
      m_dev = i_dev;
      m_pri = i_pri;
      m_phase = 1;
    end
    check_all();
    irq_ack = 1'b0;
    reti = 1'b0;
    if (was_pop) req_valid = 1'b0;
  endtask

  // Offer a request, wait for irq (bounded), then acknowledge it.
  task automatic serve(input logic [7:0] dev, input logic [2:0] pri);
    req_dev = dev; req_pri = pri; req_valid = 1'b1;
    for (int k = 0; k < 10 && m_phase != 2; k++) tick();
    if (m_phase != 2) begin
      checks++;
      failures++;
      $error("FAIL serve_wait observed=phase%0d expected=phase2", m_phase);
    end
    irq_ack = 1'b1;
    tick();
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; req_valid = 1'b0; req_dev = 8'd0; req_pri = 3'd0;
    cpu_pri = 3'd0; cpu_ie = 1'b0; irq_ack = 1'b0; reti = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("reset_vector", vector, 16'h0000);
    rst = 1'b0;

    // Basic dispatch with latency and vector.
    cpu_pri = 3'd2; cpu_ie = 1'b1; req_valid = 1'b1; req_dev = 8'hC6; req_pri = 3'd5;
    tick();
    chk("t1_pop_c1", 16'(req_pop), 16'd1);
    chk("t1_irq_c1", 16'(irq), 16'd0);
    tick();
    chk("t1_irq_c2", 16'(irq), 16'd1);
    chk("t1_vec_c2", vector, 16'hFFC6);
    tick();
    tick();
    irq_ack = 1'b1;
    tick();
    chk("t1_irq_c5", 16'(irq), 16'd0);
    chk("t1_npv_c5", 16'(new_pri_valid), 16'd1);
    chk("t1_np_c5", 16'(new_pri), 16'd5);
    chk("t1_lvl_c5", 16'(nest_level), 16'd1);

    // Equal priority and disabled CPU never preempt.
    cpu_pri = 3'd3; req_pri = 3'd3; req_dev = 8'h11; req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t2_eq_nopop", 16'(req_pop | irq), 16'd0);
    end
    req_pri = 3'd6; cpu_ie = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t2_ie_nopop", 16'(req_pop | irq), 16'd0);
    end
    req_valid = 1'b0; cpu_ie = 1'b1;
    reti = 1'b1;
    tick();
    chk("t2_restore", 16'(restore_pri), 16'd2);

    // Three nested interrupts then unwind, plus underflow.
    cpu_pri = 3'd0;
    serve(8'h30, 3'd3); cpu_pri = 3'd3;
    serve(8'h50, 3'd5); cpu_pri = 3'd5;
    serve(8'h70, 3'd7); cpu_pri = 3'd7;
    chk("t3_lvl3", 16'(nest_level), 16'd3);
    reti = 1'b1; tick(); chk("t3_r1", 16'(restore_pri), 16'd5);
    reti = 1'b1; tick(); chk("t3_r2", 16'(restore_pri), 16'd3);
    reti = 1'b1; tick(); chk("t3_r3", 16'(restore_pri), 16'd0);
    chk("t3_lvl0", 16'(nest_level), 16'd0);
    reti = 1'b1; tick();
    chk("t3_underflow", 16'(err_underflow), 16'd1);
    chk("t3_no_restore", 16'(restore_valid), 16'd0);

    // Full stack blocks admission until one reti frees a slot.
    cpu_pri = 3'd0;
    for (int i = 0; i < DEPTH; i++) serve(8'(8'h80 + i), 3'(1 + (i % 7)));
    chk("t4_full", 16'(nest_level), 16'(DEPTH));
    cpu_pri = 3'd6; req_dev = 8'h5A; req_pri = 3'd7; req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_blocked", 16'(req_pop), 16'd0);
    end
    reti = 1'b1;
    tick();
    chk("t4_pop_same", 16'(req_pop), 16'd0);
    tick();
    chk("t4_pop_next", 16'(req_pop), 16'd1);
    tick();
    irq_ack = 1'b1;
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      reti = 1'b1;
      tick();
    end
    chk("t4_drained", 16'(nest_level), 16'd0);

    // Same-edge reti and ack while pending.
    cpu_pri = 3'd1; serve(8'h41, 3'd4);
    cpu_pri = 3'd4; serve(8'h42, 3'd5);
    cpu_pri = 3'd5; req_dev = 8'h43; req_pri = 3'd6; req_valid = 1'b1;
    tick(); tick();
    chk("t5_irq", 16'(irq), 16'd1);
    irq_ack = 1'b1; reti = 1'b1;
    tick();
    chk("t5_rv", 16'(restore_valid), 16'd1);
    chk("t5_rp", 16'(restore_pri), 16'd4);
    chk("t5_npv", 16'(new_pri_valid), 16'd1);
    chk("t5_lvl", 16'(nest_level), 16'd2);
    cpu_pri = 3'd6; reti = 1'b1;
    tick();
    chk("t5_next_rp", 16'(restore_pri), 16'd5);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if (!req_valid && ($urandom % 3 == 0)) begin
        req_dev = 8'($urandom);
        req_pri = 3'($urandom_range(1, 7));
        req_valid = 1'b1;
      end
      if ($urandom % 8 == 0) cpu_pri = 3'($urandom);
      cpu_ie = ($urandom % 8) != 0;
      irq_ack = ($urandom % 3) == 0;
      reti = ($urandom % 5) == 0;
      tick();
    end

    // Clean restart, then asynchronous reset in the middle of PEND.
    rst = 1'b1; req_valid = 1'b0; irq_ack = 1'b0; reti = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    cpu_pri = 3'd0; cpu_ie = 1'b1;
    serve(8'h21, 3'd2);
    req_dev = 8'h22; req_pri = 3'd4; req_valid = 1'b1;
    tick(); tick();
    chk("t6_irq_pre", 16'(irq), 16'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_irq_rst", 16'(irq), 16'd0);
    chk("t6_vec_rst", vector, 16'h0000);
    chk("t6_lvl_rst", 16'(nest_level), 16'd0);
    req_valid = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    serve(8'h9D, 3'd3);
    chk("t6_np", 16'(new_pri), 16'd3);
    chk("t6_lvl", 16'(nest_level), 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
